// File: rtl/click_decoder_pkg.sv
// Shared types and helpers for the click decoder: FSM state encoding and a
// constant-evaluable ceil(log2) used to size the click counter.
package click_decoder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/click_decoder_gap_timer.sv
// Quiet-gap timer for the click decoder: counts press-free cycles and flags
// the all-ones value that closes a burst.
module gap_timer #(
  parameter int WINDOW_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WINDOW_WIDTH-1:0] timer_q;
  logic [WINDOW_WIDTH-1:0] timer_d;

  // Clear has priority so the owner can restart the window on any press.
  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (enable) begin
      timer_d = timer_q + WINDOW_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired = &timer_q;

endmodule

// File: rtl/click_decoder.sv
// Groups debounced press pulses into click bursts and hands each burst out as
// one counted event on a valid/ready port. Optional CLICK_DECODER_OVERRUN_EN.
module click_decoder
  import click_decoder_pkg::*;
#(
  parameter int  WINDOW_WIDTH = 8,
  parameter int  MAX_CLICKS   = 3,
  localparam int CNT_W        = clog2(MAX_CLICKS + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Press,
  input  logic             EventReady,
  input  logic             OverrunClr,
  output logic             EventValid,
  output logic [CNT_W-1:0] EventCount,
  output logic             Busy,
  output logic             Overrun
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clicks_q, clicks_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             emit;
  logic [CNT_W-1:0] emit_count;
  logic             timer_clear;
  logic             timer_en;
  logic             timer_expired;
  logic             slot_free;
  logic             overrun_set;

  gap_timer #(
    .WINDOW_WIDTH(WINDOW_WIDTH)
  ) u_gap_timer (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // A press always beats a simultaneous timer expiry: it is counted and restarts the gap.
  always_comb begin
    state_d     = state_q;
    clicks_d    = clicks_q;
    emit        = 1'b0;
    emit_count  = '0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (Press) begin
          if (MAX_CLICKS == 1) begin
            emit       = 1'b1;
            emit_count = CNT_W'(1);
          end else begin
            clicks_d = CNT_W'(1);
            state_d  = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (Press) begin
          timer_clear = 1'b1;
          if (clicks_q + CNT_W'(1) == CNT_W'(MAX_CLICKS)) begin
            emit       = 1'b1;
            emit_count = clicks_q + CNT_W'(1);
            clicks_d   = '0;
            state_d    = ST_IDLE;
          end else begin
            clicks_d = clicks_q + CNT_W'(1);
          end
        end else if (timer_expired) begin
          emit        = 1'b1;
          emit_count  = clicks_q;
          clicks_d    = '0;
          timer_clear = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        clicks_d = '0;
      end
    endcase
  end

  // The slot frees up in the very cycle it is accepted, allowing back-to-back events.
  always_comb begin
    slot_free   = !valid_q || EventReady;
    valid_d     = valid_q;
    count_d     = count_q;
    overrun_set = 1'b0;
    if (valid_q && EventReady) begin
      valid_d = 1'b0;
    end
    if (emit) begin
      if (slot_free) begin
        valid_d = 1'b1;
        count_d = emit_count;
      end else begin
`ifdef CLICK_DECODER_OVERRUN_EN
        overrun_set = 1'b1;
`else
        count_d = emit_count;
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      clicks_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      clicks_q <= clicks_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

`ifdef CLICK_DECODER_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Set beats clear when a loss and a clear request coincide.
  always_comb begin
    overrun_d = overrun_q;
    if (OverrunClr) begin
      overrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign Overrun = overrun_q;
`else
  logic unused_overrun;
  assign unused_overrun = OverrunClr | overrun_set;
  assign Overrun        = 1'b0;
`endif

  assign EventValid = valid_q;
  assign EventCount = count_q;
  assign Busy       = (state_q == ST_COUNT);

endmodule

// File: tb/tb_click_decoder.sv
// Directed testbench for click_decoder with a short gap window (8 cycles) and
// three-click bursts; expectations follow the macro setting of the build.
module tb_click_decoder;

  localparam int WW    = 3;
  localparam int MAXC  = 3;
  localparam int CNT_W = 2;

  logic             Clk;
  logic             Rst_n;
  logic             Press;
  logic             EventReady;
  logic             OverrunClr;
  logic             EventValid;
  logic [CNT_W-1:0] EventCount;
  logic             Busy;
  logic             Overrun;

  int errors = 0;
  int checks = 0;

  click_decoder #(
    .WINDOW_WIDTH(WW),
    .MAX_CLICKS  (MAXC)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Press     (Press),
    .EventReady(EventReady),
    .OverrunClr(OverrunClr),
    .EventValid(EventValid),
    .EventCount(EventCount),
    .Busy      (Busy),
    .Overrun   (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press_once();
    Press = 1'b1;
    tick();
    Press = 1'b0;
  endtask

  task automatic test_reset();
    bit seen_valid;
    EventReady = 1'b0;
    press_once();
    repeat (8) tick();
    press_once();
    checks++;
    if (EventValid !== 1'b1 || EventCount !== 2'd1 || Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_prep: valid=%b count=%0d busy=%b, required 1/1/1", EventValid, EventCount, Busy);
    end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (EventValid !== 1'b0 || EventCount !== 2'd0 || Busy !== 1'b0 || Overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: valid=%b count=%0d busy=%b overrun=%b, required all 0", EventValid, EventCount, Busy, Overrun);
    end
    #1 Rst_n = 1'b1;
    EventReady = 1'b1;
    tick();
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (EventValid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin
      errors++;
      $display("[TB] FAIL reset_idle: EventValid rose during idle, required 0");
    end
  endtask

  task automatic test_single();
    bit early;
    press_once();
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_busy: Busy=%b, required 1", Busy);
    end
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (EventValid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("[TB] FAIL single_early: EventValid before 8 edges, required 0");
    end
    tick();
    checks++;
    if (EventValid !== 1'b1 || EventCount !== 2'd1 || Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_event: valid=%b count=%0d busy=%b, required 1/1/0", EventValid, EventCount, Busy);
    end
    tick();
    checks++;
    if (EventValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pulse: EventValid=%b after accept, required 0", EventValid);
    end
  endtask

  task automatic test_double();
    bit early;
    press_once();
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (EventValid !== 1'b0) early = 1'b1;
    end
    press_once();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (EventValid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("[TB] FAIL double_early: event seen before burst closed, required none");
    end
    tick();
    checks++;
    if (EventValid !== 1'b1 || EventCount !== 2'd2) begin
      errors++;
      $display("[TB] FAIL double_event: valid=%b count=%0d, required 1/2", EventValid, EventCount);
    end
    tick();
  endtask

  task automatic test_max_restart();
    press_once();
    tick();
    press_once();
    tick();
    press_once();
    checks++;
    if (EventValid !== 1'b1 || EventCount !== 2'd3 || Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_event: valid=%b count=%0d busy=%b, required 1/3/0", EventValid, EventCount, Busy);
    end
    tick();
    tick();
    press_once();
    checks++;
    if (Busy !== 1'b1 || EventValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_restart: busy=%b valid=%b, required 1/0", Busy, EventValid);
    end
    repeat (8) tick();
    checks++;
    if (EventValid !== 1'b1 || EventCount !== 2'd1) begin
      errors++;
      $display("[TB] FAIL max_restart_event: valid=%b count=%0d, required 1/1", EventValid, EventCount);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] exp_second;
    logic             exp_ovr;
`ifdef CLICK_DECODER_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    EventReady = 1'b0;
    press_once();
    repeat (8) tick();
    checks++;
    if (EventValid !== 1'b1 || EventCount !== 2'd1) begin
      errors++;
      $display("[TB] FAIL bp_first: valid=%b count=%0d, required 1/1", EventValid, EventCount);
    end
    press_once();
    repeat (8) tick();
    checks++;
    if (EventValid !== 1'b1 || EventCount !== 2'd1 || Overrun !== exp_ovr) begin
      errors++;
      $display("[TB] FAIL bp_single_overrun: valid=%b count=%0d overrun=%b, required 1/1/%b", EventValid, EventCount, Overrun, exp_ovr);
    end
    OverrunClr = 1'b1;
    tick();
    OverrunClr = 1'b0;
    checks++;
    if (Overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_clear: Overrun=%b, required 0", Overrun);
    end
    EventReady = 1'b1;
    tick();
    checks++;
    if (EventValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_accept: EventValid=%b, required 0", EventValid);
    end
    EventReady = 1'b0;
    press_once();
    repeat (8) tick();
    press_once();
    tick();
    tick();
    press_once();
    repeat (8) tick();
`ifdef CLICK_DECODER_OVERRUN_EN
    exp_second = 2'd1;
`else
    exp_second = 2'd2;
`endif
    checks++;
    if (EventValid !== 1'b1 || EventCount !== exp_second || Overrun !== exp_ovr) begin
      errors++;
      $display("[TB] FAIL bp_double_overrun: valid=%b count=%0d overrun=%b, required 1/%0d/%b", EventValid, EventCount, Overrun, exp_second, exp_ovr);
    end
    OverrunClr = 1'b1;
    EventReady = 1'b1;
    tick();
    OverrunClr = 1'b0;
    checks++;
    if (EventValid !== 1'b0 || Overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: valid=%b overrun=%b, required 0/0", EventValid, Overrun);
    end
  endtask

  task automatic test_edge_cases();
    bit early;
    bit seen_valid;
    press_once();
    repeat (7) tick();
    press_once();
    checks++;
    if (EventValid !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_expiry_press: valid=%b busy=%b, required 0/1", EventValid, Busy);
    end
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (EventValid !== 1'b0) early = 1'b1;
    end
    tick();
    checks++;
    if (early || EventValid !== 1'b1 || EventCount !== 2'd2) begin
      errors++;
      $display("[TB] FAIL edge_expiry_count: early=%b valid=%b count=%0d, required 0/1/2", early, EventValid, EventCount);
    end
    tick();
    press_once();
    tick();
    tick();
    #2 Rst_n = 1'b0;
    #2 Rst_n = 1'b1;
    tick();
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (EventValid !== 1'b0 || Busy !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin
      errors++;
      $display("[TB] FAIL edge_reset_burst: activity after mid-burst reset, required none");
    end
  endtask

  initial begin
    Rst_n      = 1'b0;
    Press      = 1'b0;
    EventReady = 1'b1;
    OverrunClr = 1'b0;
    tick();
    tick();
    checks++;
    if (EventValid !== 1'b0 || EventCount !== 2'd0 || Busy !== 1'b0 || Overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial: valid=%b count=%0d busy=%b overrun=%b, required all 0", EventValid, EventCount, Busy, Overrun);
    end
    Rst_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_double();
    test_max_restart();
    test_backpressure();
    test_edge_cases();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
